bin_load_ctrl: RTL and testbench
================================

BIN_LOAD_CTRL -- requirements
Module: bin_load_ctrl

Interface
REQ-001 Parameters: NUM_CLAUSES=8 (clause rows per bin), NUM_VARS=8 (vars per row), NUM_LVLS=8 (level slots), WIDTH_LVL=16, WIDTH_VAR_STATES=19, WIDTH_LVL_STATES=11, WIDTH_CYC=24 (cycle counter width), TIMEOUT_CYC=1_000_000 (run-phase limit, 0 = disabled).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports (name dir width meaning):
- clk  in  1  clock
- rst  in  1  async reset, active-low
- start_i  in  1  begin one bin run; accepted only in IDLE
- abort_i  in  1  abandon current run
- rb_en_i  in  1  sampled with start_i; 1 = clause readback after run
- cur_bin_num_i, load_lvl_i, base_lvl_i  in  WIDTH_LVL each  run context, sampled with start_i
- vs_i  in  WIDTH_VAR_STATES*NUM_VARS  var states, sampled with start_i
- ls_i  in  WIDTH_LVL_STATES*NUM_LVLS  level states, sampled with start_i
- cl_valid_i / cl_ready_o  in / out  1  clause-in handshake
- cl_data_i  in  NUM_VARS*3  clause row, row 0 first
- wr_carray_o, rd_carray_o  out  NUM_CLAUSES  one-hot row strobes to engine
- clause_o  out  NUM_VARS*3  row write data; clause_i  in  NUM_VARS*3  row read data
- wr_var_states_o  out  NUM_VARS; vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS
- wr_lvl_states_o  out  NUM_LVLS; lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS
- start_core_o, base_lvl_en_o  out  1; cur_bin_num_o, load_lvl_o, base_lvl_o  out  WIDTH_LVL
- done_core_i, sat_i, unsat_i  in  1; bkt_lvl_i  in  WIDTH_LVL  engine results
- rb_valid_o / rb_ready_i  out / in  1; rb_data_o  out  NUM_VARS*3  readback stream
- busy_o, done_o  out  1; result_o  out  2  (00 none, 01 sat, 10 unsat, 11 timeout/abort)
- bkt_lvl_o  out  WIDTH_LVL; cycles_o  out  WIDTH_CYC  run-phase cycle count

Function
REQ-004 FSM states: IDLE, LOAD_C, LOAD_VS, LOAD_LS, START, RUN, RDBK_REQ, RDBK_OUT, FIN.
REQ-005 IDLE: start_i=1 -> capture context/vs_i/ls_i/rb_en_i, row=0, cycles_o=0, result_o=00 -> LOAD_C; busy_o=1 in every state except IDLE.
REQ-006 LOAD_C: cl_ready_o=1; each handshake cycle drives wr_carray_o=1<<row, clause_o=cl_data_i in the same cycle, row+1; after row NUM_CLAUSES-1 -> LOAD_VS; no handshake = all strobes 0.
REQ-007 LOAD_VS: one cycle, wr_var_states_o=all ones, vars_states_o=captured vs -> LOAD_LS.
REQ-008 LOAD_LS: one cycle, wr_lvl_states_o=all ones, lvl_states_o=captured ls -> START.
REQ-009 START: one cycle, start_core_o=1, base_lvl_en_o=1; cur_bin_num_o/load_lvl_o/base_lvl_o hold captured values from LOAD_C to FIN -> RUN.
REQ-010 RUN: cycles_o increments each cycle, saturating at all ones; done_core_i=1 -> latch result_o (sat_i -> 01, else unsat_i -> 10, both 0 -> 00, sat wins if both), latch bkt_lvl_o; next RDBK_REQ if rb_en, else FIN.
REQ-011 RUN timeout: TIMEOUT_CYC!=0 and cycles_o==TIMEOUT_CYC-1 without done_core_i -> result_o=11, FIN, no readback; done_core_i in that same cycle wins.
REQ-012 RDBK_REQ: one cycle, rd_carray_o=1<<row (row reset to 0 on RUN exit) -> RDBK_OUT; clause_i valid exactly 1 cycle after rd_carray_o.
REQ-013 RDBK_OUT: first cycle registers clause_i into rb_data_o; rb_valid_o=1 held stable until rb_ready_i=1; on handshake row+1 -> RDBK_REQ, after row NUM_CLAUSES-1 -> FIN.
REQ-014 FIN: done_o=1 for exactly one cycle -> IDLE; result_o, bkt_lvl_o, cycles_o hold until next accepted start_i.
REQ-015 abort_i=1 in any non-IDLE state: next state FIN with result_o=11; strobes and rb_valid_o 0 from the next cycle; abort has priority over all transitions; ignored in IDLE.
REQ-016 start_i outside IDLE is ignored; strobe outputs are one-hot or zero, never multi-bit.

Reset
REQ-017 rst=0 asynchronously forces IDLE; all outputs 0, including result_o=00, cycles_o=0, and captured registers; mid-run reset drops the run with no done_o pulse.

Structure
REQ-018 Shared package holds the FSM state enum, the result encoding constants, and the 3-bit literal encoding width constant.
REQ-019 One sub-module: bin_rdbk_buf (single-entry registered skid buffer for clause_i -> rb_data_o with valid/ready).

Verification
REQ-020 bin with rows 0..2 nonzero, cl_valid_i continuous -> wr_carray_o 01,02,04..80 on 8 consecutive cycles, then 1-cycle wr_var_states_o=FF, wr_lvl_states_o=FF, start_core_o.
REQ-021 cl_valid_i toggling 1/0 -> exactly 8 write strobes spread over 16 cycles, cl_data_i row order preserved.
REQ-022 done_core_i with sat_i=1, bkt_lvl_i=3 after 20 RUN cycles, rb_en_i=0 -> result_o=01, bkt_lvl_o=3, cycles_o=20, done_o single pulse.
REQ-023 rb_en_i=1, rb_ready_i low 5 cycles per row -> 8 rb_data_o words equal to clause_i rows, each held stable while rb_valid_o=1.
REQ-024 TIMEOUT_CYC=10, no done_core_i -> FIN after 10 RUN cycles, result_o=11, no rd_carray_o strobes.
REQ-025 abort_i during LOAD_C row 4, and rst=0 during RUN -> abort: done_o pulse, result_o=11; reset: outputs 0 immediately, no done_o.

Source files
------------

// File: rtl/bin_load_ctrl_pkg.sv
// Shared encodings for the bin load controller: FSM states, result codes, literal width.
package bin_load_ctrl_pkg;

    localparam int LIT_W = 3;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_LOAD_C   = 4'd1;
    localparam state_t S_LOAD_VS  = 4'd2;
    localparam state_t S_LOAD_LS  = 4'd3;
    localparam state_t S_START    = 4'd4;
    localparam state_t S_RUN      = 4'd5;
    localparam state_t S_RDBK_REQ = 4'd6;
    localparam state_t S_RDBK_OUT = 4'd7;
    localparam state_t S_FIN      = 4'd8;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_SAT   = 2'b01;
    localparam logic [1:0] RES_UNSAT = 2'b10;
    localparam logic [1:0] RES_TMO   = 2'b11;

endpackage

// File: rtl/bin_rdbk_buf.sv
// Single-entry registered buffer for readback rows: load captures din, out_vld holds
// data stable until out_rdy; flush drops the entry. One cycle load-to-valid.
module bin_rdbk_buf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
            dout    <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
            dout    <= din;
        end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/bin_load_ctrl.sv
// Loads one bin (clause rows, var/level states) into the solver engine, runs it, optionally
// streams the clause rows back; clause input and readback use valid/ready, abort forces FIN.
module bin_load_ctrl
    import bin_load_ctrl_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_CYC        = 24,
    parameter int TIMEOUT_CYC      = 1_000_000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic                                 abort_i,
    input  logic                                 rb_en_i,
    input  logic [WIDTH_LVL-1:0]                 cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_i,
    input  logic                                 cl_valid_i,
    output logic                                 cl_ready_o,
    input  logic [NUM_VARS*LIT_W-1:0]            cl_data_i,
    output logic [NUM_CLAUSES-1:0]               wr_carray_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    output logic [NUM_VARS*LIT_W-1:0]            clause_o,
    input  logic [NUM_VARS*LIT_W-1:0]            clause_i,
    output logic [NUM_VARS-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    output logic                                 start_core_o,
    output logic                                 base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 load_lvl_o,
    output logic [WIDTH_LVL-1:0]                 base_lvl_o,
    input  logic                                 done_core_i,
    input  logic                                 sat_i,
    input  logic                                 unsat_i,
    input  logic [WIDTH_LVL-1:0]                 bkt_lvl_i,
    output logic                                 rb_valid_o,
    input  logic                                 rb_ready_i,
    output logic [NUM_VARS*LIT_W-1:0]            rb_data_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [1:0]                           result_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_CYC-1:0]                 cycles_o
);

    localparam int RW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [RW-1:0]        LAST_ROW = RW'(NUM_CLAUSES - 1);
    localparam logic [WIDTH_CYC-1:0] TO_LAST  = WIDTH_CYC'(TIMEOUT_CYC - 1);

    state_t                 state, state_nxt;
    logic [RW-1:0]          row;
    logic                   rb_en_q, rd_pend;
    logic                   cl_hs, rb_hs, last_row, run_tmo, abort_act;
    logic [NUM_CLAUSES-1:0] row_oh;

    assign last_row  = (row == LAST_ROW);
    assign row_oh    = NUM_CLAUSES'(1) << row;
    assign cl_hs     = (state == S_LOAD_C) && cl_valid_i;
    assign rb_hs     = (state == S_RDBK_OUT) && rb_valid_o && rb_ready_i;
    assign run_tmo   = (state == S_RUN) && (TIMEOUT_CYC != 0) && (cycles_o == TO_LAST);
    // FIN is already terminating; re-entering it would stretch the done pulse.
    assign abort_act = abort_i && (state != S_IDLE) && (state != S_FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_i) state_nxt = S_LOAD_C;
            S_LOAD_C:   if (cl_hs && last_row) state_nxt = S_LOAD_VS;
            S_LOAD_VS:  state_nxt = S_LOAD_LS;
            S_LOAD_LS:  state_nxt = S_START;
            S_START:    state_nxt = S_RUN;
            S_RUN: begin
                if (done_core_i)  state_nxt = rb_en_q ? S_RDBK_REQ : S_FIN;
                else if (run_tmo) state_nxt = S_FIN;
            end
            S_RDBK_REQ: state_nxt = S_RDBK_OUT;
            S_RDBK_OUT: if (rb_hs) state_nxt = last_row ? S_FIN : S_RDBK_REQ;
            S_FIN:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (abort_act) state_nxt = S_FIN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            row           <= '0;
            rb_en_q       <= 1'b0;
            rd_pend       <= 1'b0;
            cur_bin_num_o <= '0;
            load_lvl_o    <= '0;
            base_lvl_o    <= '0;
            vars_states_o <= '0;
            lvl_states_o  <= '0;
            result_o      <= RES_NONE;
            bkt_lvl_o     <= '0;
            cycles_o      <= '0;
        end else begin
            state   <= state_nxt;
            // clause_i answers one cycle after rd_carray_o, so capture is deferred a cycle
            rd_pend <= (state == S_RDBK_REQ) && !abort_act;
            if (state == S_IDLE && start_i) begin
                row           <= '0;
                rb_en_q       <= rb_en_i;
                cur_bin_num_o <= cur_bin_num_i;
                load_lvl_o    <= load_lvl_i;
                base_lvl_o    <= base_lvl_i;
                vars_states_o <= vs_i;
                lvl_states_o  <= ls_i;
                result_o      <= RES_NONE;
                bkt_lvl_o     <= '0;
                cycles_o      <= '0;
            end
            if (cl_hs || rb_hs) row <= last_row ? '0 : row + 1'b1;
            if (state == S_RUN) begin
                if (cycles_o != '1) cycles_o <= cycles_o + 1'b1;
                if (done_core_i) begin
                    result_o  <= sat_i ? RES_SAT : (unsat_i ? RES_UNSAT : RES_NONE);
                    bkt_lvl_o <= bkt_lvl_i;
                    row       <= '0;
                end else if (run_tmo) begin
                    result_o  <= RES_TMO;
                end
            end
            if (abort_act) result_o <= RES_TMO;
        end
    end

    assign busy_o          = (state != S_IDLE);
    assign done_o          = (state == S_FIN);
    assign cl_ready_o      = (state == S_LOAD_C);
    assign wr_carray_o     = cl_hs ? row_oh : '0;
    assign clause_o        = cl_hs ? cl_data_i : '0;
    assign rd_carray_o     = (state == S_RDBK_REQ) ? row_oh : '0;
    assign wr_var_states_o = {NUM_VARS{state == S_LOAD_VS}};
    assign wr_lvl_states_o = {NUM_LVLS{state == S_LOAD_LS}};
    assign start_core_o    = (state == S_START);
    assign base_lvl_en_o   = (state == S_START);

    bin_rdbk_buf #(
        .W (NUM_VARS*LIT_W)
    ) u_rdbk_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_act),
        .load    (rd_pend),
        .din     (clause_i),
        .out_rdy (rb_ready_i),
        .out_vld (rb_valid_o),
        .dout    (rb_data_o)
    );

endmodule

// File: tb/tb_bin_load_ctrl.sv
// Bench for bin_load_ctrl: vector table, hand sequences and randomized runs against a run-level model.
module tb_bin_load_ctrl;
    import bin_load_ctrl_pkg::*;

    localparam int NC = 8, NV = 8, NL = 8, WL = 16, WVS = 19, WLS = 11, WC = 24, CW = NV*3;

    logic clk, rst, start_i, abort_i, rb_en_i, cl_valid_i, done_core_i, sat_i, unsat_i, rb_ready_i;
    logic [WL-1:0] cur_bin_num_i, load_lvl_i, base_lvl_i, bkt_lvl_i;
    logic [WVS*NV-1:0] vs_i;
    logic [WLS*NL-1:0] ls_i;
    logic [CW-1:0] cl_data_i, clause_i;

    logic cl_ready_o, start_core_o, base_lvl_en_o, rb_valid_o, busy_o, done_o;
    logic [NC-1:0] wr_carray_o, rd_carray_o;
    logic [CW-1:0] clause_o, rb_data_o;
    logic [NV-1:0] wr_var_states_o;
    logic [NL-1:0] wr_lvl_states_o;
    logic [WVS*NV-1:0] vars_states_o;
    logic [WLS*NL-1:0] lvl_states_o;
    logic [WL-1:0] cur_bin_num_o, load_lvl_o, base_lvl_o, bkt_lvl_o;
    logic [1:0] result_o;
    logic [WC-1:0] cycles_o;

    // second instance with a short run limit, sharing all inputs
    logic t_cl_ready, t_start_core, t_base_lvl_en, t_rb_valid, t_busy, t_done;
    logic [NC-1:0] t_wr_carray, t_rd_carray;
    logic [CW-1:0] t_clause, t_rb_data;
    logic [NV-1:0] t_wr_vs;
    logic [NL-1:0] t_wr_ls;
    logic [WVS*NV-1:0] t_vs;
    logic [WLS*NL-1:0] t_ls;
    logic [WL-1:0] t_cur_bin, t_load_lvl, t_base_lvl, t_bkt_lvl;
    logic [1:0] t_result;
    logic [WC-1:0] t_cycles;

    bin_load_ctrl #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
        .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS), .WIDTH_CYC(WC), .TIMEOUT_CYC(1_000_000)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .rb_en_i(rb_en_i),
        .cur_bin_num_i(cur_bin_num_i), .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i),
        .vs_i(vs_i), .ls_i(ls_i), .cl_valid_i(cl_valid_i), .cl_ready_o(cl_ready_o), .cl_data_i(cl_data_i),
        .wr_carray_o(wr_carray_o), .rd_carray_o(rd_carray_o), .clause_o(clause_o), .clause_i(clause_i),
        .wr_var_states_o(wr_var_states_o), .vars_states_o(vars_states_o),
        .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o),
        .start_core_o(start_core_o), .base_lvl_en_o(base_lvl_en_o), .cur_bin_num_o(cur_bin_num_o),
        .load_lvl_o(load_lvl_o), .base_lvl_o(base_lvl_o), .done_core_i(done_core_i), .sat_i(sat_i),
        .unsat_i(unsat_i), .bkt_lvl_i(bkt_lvl_i), .rb_valid_o(rb_valid_o), .rb_ready_i(rb_ready_i),
        .rb_data_o(rb_data_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .bkt_lvl_o(bkt_lvl_o), .cycles_o(cycles_o));

    bin_load_ctrl #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
        .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS), .WIDTH_CYC(WC), .TIMEOUT_CYC(10)) dut_to (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .rb_en_i(rb_en_i),
        .cur_bin_num_i(cur_bin_num_i), .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i),
        .vs_i(vs_i), .ls_i(ls_i), .cl_valid_i(cl_valid_i), .cl_ready_o(t_cl_ready), .cl_data_i(cl_data_i),
        .wr_carray_o(t_wr_carray), .rd_carray_o(t_rd_carray), .clause_o(t_clause), .clause_i(clause_i),
        .wr_var_states_o(t_wr_vs), .vars_states_o(t_vs), .wr_lvl_states_o(t_wr_ls), .lvl_states_o(t_ls),
        .start_core_o(t_start_core), .base_lvl_en_o(t_base_lvl_en), .cur_bin_num_o(t_cur_bin),
        .load_lvl_o(t_load_lvl), .base_lvl_o(t_base_lvl), .done_core_i(done_core_i), .sat_i(sat_i),
        .unsat_i(unsat_i), .bkt_lvl_i(bkt_lvl_i), .rb_valid_o(t_rb_valid), .rb_ready_i(rb_ready_i),
        .rb_data_o(t_rb_data), .busy_o(t_busy), .done_o(t_done), .result_o(t_result),
        .bkt_lvl_o(t_bkt_lvl), .cycles_o(t_cycles));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [NC-1:0] oh(input int i);
        logic [NC-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic logic [1:0] res_model(input logic s, input logic u);
        if (s) return 2'b01;
        if (u) return 2'b10;
        return 2'b00;
    endfunction

    // engine clause array: write on strobe, answer reads one cycle later
    logic [CW-1:0] eng_mem [NC];
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (wr_carray_o[i]) eng_mem[i] <= clause_o;
            if (rd_carray_o[i]) clause_i <= eng_mem[i];
        end
    end

    // passive monitor: only this block writes these
    logic [CW-1:0] wq[$], rbq[$];
    logic [NC-1:0] wsq[$];
    int done_cnt = 0, t_done_cnt = 0, t_rd_cnt = 0, onehot_bad = 0, unstable = 0;
    logic prev_hold = 1'b0;
    logic [CW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (wr_carray_o != '0) begin wq.push_back(clause_o); wsq.push_back(wr_carray_o); end
        if (!$onehot0(wr_carray_o) || !$onehot0(rd_carray_o)) onehot_bad++;
        if (prev_hold && rb_valid_o && rb_data_o !== prev_data) unstable++;
        if (rb_valid_o && rb_ready_i) rbq.push_back(rb_data_o);
        prev_hold = rb_valid_o && !rb_ready_i;
        prev_data = rb_data_o;
        if (done_o) done_cnt++;
        if (t_done) t_done_cnt++;
        if (t_rd_carray != '0) t_rd_cnt++;
    end

    logic [CW-1:0] rows [NC];

    task automatic begin_run(input logic rbe);
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        vs_i = r[WVS*NV-1:0]; ls_i = r[WLS*NL-1:0];
        cur_bin_num_i = WL'($urandom()); load_lvl_i = WL'($urandom()); base_lvl_i = WL'($urandom());
        rb_en_i = rbe; start_i = 1'b1;
        step();
        start_i = 1'b0; rb_en_i = 1'b0;
    endtask

    task automatic load_rows(input logic toggle);
        int k = 0, b = 0;
        while (k < NC && b < 100) begin
            cl_valid_i = toggle ? (b % 2 == 0) : 1'b1;
            cl_data_i = rows[k];
            @(negedge clk);
            if (cl_valid_i && cl_ready_o) k++;
            step();
            b++;
        end
        cl_valid_i = 1'b0;
        chk("load rows accepted", k, NC);
        chk("load cycles", b, toggle ? 2*NC-1 : NC);
    endtask

    // returns in the first RUN cycle
    task automatic wait_core(input string tag);
        int b = 0;
        while (b < 20) begin
            @(negedge clk);
            if (start_core_o) break;
            step();
            b++;
        end
        chk({tag, " start_core seen"}, b < 20, 1'b1);
        step();
    endtask

    task automatic finish_wait(input string tag, input int stall);
        int b = 0, sc = 0;
        logic seen = 1'b0;
        while (!seen && b < 2000) begin
            rb_ready_i = (sc >= stall);
            @(negedge clk);
            seen = done_o;
            if (rb_valid_o) sc = rb_ready_i ? 0 : sc + 1;
            step();
            b++;
        end
        rb_ready_i = 1'b0;
        chk({tag, " done seen"}, seen, 1'b1);
    endtask

    task automatic run_bin(input string tag, input logic s, input logic u, input logic [WL-1:0] bkt,
                           input int run_len, input logic rbe, input int stall, input logic toggle,
                           input logic [1:0] exp_res, input int exp_cyc);
        int w0, r0, d0, nrb;
        for (int i = 0; i < NC; i++) rows[i] = CW'($urandom());
        w0 = wq.size(); r0 = rbq.size(); d0 = done_cnt;
        begin_run(rbe);
        load_rows(toggle);
        wait_core(tag);
        repeat (run_len - 1) step();
        done_core_i = 1'b1; sat_i = s; unsat_i = u; bkt_lvl_i = bkt;
        step();
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0;
        finish_wait(tag, stall);
        @(negedge clk);
        chk({tag, " done single"}, done_cnt - d0, 1);
        chk({tag, " idle"}, busy_o, 1'b0);
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " bkt"}, bkt_lvl_o, bkt);
        chk({tag, " cycles"}, cycles_o, exp_cyc);
        chk({tag, " nwrites"}, wq.size() - w0, NC);
        for (int i = 0; i < NC && w0 + i < wq.size(); i++) begin
            chk({tag, " wr data"}, wq[w0+i], rows[i]);
            chk({tag, " wr strobe"}, wsq[w0+i], oh(i));
        end
        nrb = rbq.size() - r0;
        chk({tag, " nrdbk"}, nrb, rbe ? NC : 0);
        for (int i = 0; i < nrb && i < NC; i++) chk({tag, " rdbk data"}, rbq[r0+i], rows[i]);
        step();
    endtask

    task automatic seq_load();
        logic [WL-1:0] cb, ll, bl;
        logic [WVS*NV-1:0] vsv;
        logic [WLS*NL-1:0] lsv;
        for (int i = 0; i < NC; i++) rows[i] = (i < 3) ? CW'(24'hA5A000 + i + 1) : '0;
        begin_run(1'b0);
        cb = cur_bin_num_i; ll = load_lvl_i; bl = base_lvl_i; vsv = vs_i; lsv = ls_i;
        for (int r = 0; r < NC; r++) begin
            cl_valid_i = 1'b1; cl_data_i = rows[r];
            start_i = (r == 3); cur_bin_num_i = (r == 3) ? ~cb : cb;
            @(negedge clk);
            chk("seq wr strobe", wr_carray_o, oh(r));
            chk("seq wr data", clause_o, rows[r]);
            step();
        end
        start_i = 1'b0; cl_valid_i = 1'b0; vs_i = '0; ls_i = '0;
        @(negedge clk);
        chk("seq wr_var_states", wr_var_states_o, 8'hFF);
        chk("seq vars_states", vars_states_o, vsv);
        chk("seq wr idle", wr_carray_o, 0);
        step();
        @(negedge clk);
        chk("seq wr_lvl_states", wr_lvl_states_o, 8'hFF);
        chk("seq lvl_states", lvl_states_o, lsv);
        chk("seq wr_var done", wr_var_states_o, 0);
        step();
        @(negedge clk);
        chk("seq start_core", start_core_o, 1'b1);
        chk("seq base_lvl_en", base_lvl_en_o, 1'b1);
        chk("seq cur_bin held", cur_bin_num_o, cb);
        chk("seq load_lvl", load_lvl_o, ll);
        chk("seq base_lvl", base_lvl_o, bl);
        step();
        @(negedge clk);
        chk("seq start_core 1cyc", start_core_o, 1'b0);
        done_core_i = 1'b1; unsat_i = 1'b1; bkt_lvl_i = 16'd4;
        step();
        done_core_i = 1'b0; unsat_i = 1'b0;
        finish_wait("seq", 0);
        chk("seq result", result_o, 2'b10);
        chk("seq bkt", bkt_lvl_o, 16'd4);
        chk("seq cycles", cycles_o, 1);
    endtask

    task automatic seq_abort();
        for (int i = 0; i < NC; i++) rows[i] = CW'($urandom());
        begin_run(1'b1);
        for (int r = 0; r < 4; r++) begin cl_valid_i = 1'b1; cl_data_i = rows[r]; step(); end
        cl_valid_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        chk("abort busy", busy_o, 1'b1);
        step();
        abort_i = 1'b0;
        @(negedge clk);
        chk("abort done", done_o, 1'b1);
        chk("abort result", result_o, 2'b11);
        chk("abort strobes", {wr_carray_o, rd_carray_o, rb_valid_o, cl_ready_o}, 0);
        step();
        @(negedge clk);
        chk("abort done 1cyc", done_o, 1'b0);
        chk("abort idle", busy_o, 1'b0);
        chk("abort result hold", result_o, 2'b11);
        step();
    endtask

    task automatic seq_timeout();
        int n = 1, rd0, td0;
        for (int i = 0; i < NC; i++) rows[i] = CW'($urandom());
        rd0 = t_rd_cnt; td0 = t_done_cnt;
        begin_run(1'b0);
        load_rows(1'b0);
        wait_core("tmo");
        while (n < 40) begin
            @(negedge clk);
            if (t_done) break;
            step();
            n++;
        end
        chk("tmo fin cycle", n, 11);
        chk("tmo result", t_result, 2'b11);
        chk("tmo cycles", t_cycles, 10);
        chk("tmo main still busy", busy_o, 1'b1);
        step();
        done_core_i = 1'b1; sat_i = 1'b1;
        step();
        done_core_i = 1'b0; sat_i = 1'b0;
        finish_wait("tmo main", 0);
        chk("tmo main result", result_o, 2'b01);
        chk("tmo no reads", t_rd_cnt - rd0, 0);
        chk("tmo single done", t_done_cnt - td0, 1);
        chk("tmo result hold", t_result, 2'b11);
    endtask

    task automatic seq_reset();
        int d0;
        for (int i = 0; i < NC; i++) rows[i] = CW'($urandom());
        begin_run(1'b1);
        load_rows(1'b0);
        wait_core("rst");
        step(); step();
        chk("rst pre cycles", cycles_o, 2);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("rst busy", busy_o, 1'b0);
        chk("rst result/cycles/bkt", {result_o, cycles_o, bkt_lvl_o}, 0);
        chk("rst context", {cur_bin_num_o, load_lvl_o, base_lvl_o, vars_states_o, lvl_states_o}, 0);
        chk("rst strobes", {wr_carray_o, rd_carray_o, start_core_o, rb_valid_o, done_o}, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        chk("rst no done", done_cnt - d0, 0);
    endtask

    typedef struct {
        logic s; logic u; logic [WL-1:0] bkt; int run_len; logic rbe; int stall; logic toggle;
        logic [1:0] exp_res; int exp_cyc;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; rb_en_i = 1'b0; cl_valid_i = 1'b0; cl_data_i = '0;
        cur_bin_num_i = '0; load_lvl_i = '0; base_lvl_i = '0; vs_i = '0; ls_i = '0;
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; bkt_lvl_i = '0; rb_ready_i = 1'b0;
        tbl[0] = '{1'b1, 1'b0, 16'd3, 20, 1'b0, 0, 1'b0, 2'b01, 20};
        tbl[1] = '{1'b0, 1'b1, 16'd7, 5, 1'b1, 5, 1'b0, 2'b10, 5};
        tbl[2] = '{1'b1, 1'b1, 16'd9, 1, 1'b0, 0, 1'b1, 2'b01, 1};
        tbl[3] = '{1'b0, 1'b0, 16'd2, 3, 1'b1, 1, 1'b1, 2'b00, 3};

        repeat (3) step();
        chk("reset busy/done", {busy_o, done_o, cl_ready_o}, 0);
        chk("reset result", result_o, 2'b00);
        chk("reset cycles", cycles_o, 0);
        chk("reset outputs", {wr_carray_o, rd_carray_o, rb_valid_o, start_core_o, cur_bin_num_o}, 0);
        rst = 1'b1;
        step();

        seq_load();
        for (int v = 0; v < 4; v++)
            run_bin($sformatf("vec%0d", v), tbl[v].s, tbl[v].u, tbl[v].bkt, tbl[v].run_len, tbl[v].rbe,
                    tbl[v].stall, tbl[v].toggle, tbl[v].exp_res, tbl[v].exp_cyc);
        seq_abort();
        seq_timeout();
        for (int n = 0; n < 16; n++) begin
            logic s, u, rbe, tg;
            int len;
            s = 1'($urandom()); u = 1'($urandom()); rbe = 1'($urandom()); tg = 1'($urandom());
            len = int'($urandom_range(1, 40));
            run_bin($sformatf("rnd%0d", n), s, u, WL'($urandom()), len, rbe,
                    int'($urandom_range(0, 3)), tg, res_model(s, u), len);
        end
        seq_reset();

        chk("strobes one-hot", onehot_bad, 0);
        chk("rb_data stable", unstable, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
